// File: rtl/fakeram130_1rw_param.sv
// Parametrised single-port (1RW) SRAM model with per-bit write mask,
// post-reset init engine, 1- or 2-cycle read pipeline and sticky error flags.
module fakeram130_1rw_param #(
  parameter int              BITS         = 32,
  parameter int              WORD_DEPTH   = 1024,
  parameter int              ADDR_WIDTH   = 10,
  parameter int              READ_LATENCY = 1,
  parameter logic [BITS-1:0] INIT_VALUE   = '0,
  parameter bit              INIT_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  output logic                  ready_out,
  output logic                  busy_err_out,
  output logic                  oob_err_out
);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  localparam state_t                RESET_STATE = INIT_EN ? ST_INIT : ST_IDLE;
  // One extra bit so the range compare stays meaningful when WORD_DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [BITS-1:0] mem [WORD_DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  busy_err_q, busy_err_d;
  logic                  oob_err_q, oob_err_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [BITS-1:0]       s1_data_q, s1_data_d;

  logic                  accept;
  logic                  in_range;
  logic                  rd_accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [BITS-1:0]       mem_wdata;
  logic [BITS-1:0]       mem_wmask;
  logic [BITS-1:0]       rd_word;

  assign ready_out    = (state_q == ST_IDLE);
  assign busy_err_out = busy_err_q;
  assign oob_err_out  = oob_err_q;

  // Access decode, init sequencing, write-port steering and flag updates.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_in;
    mem_wdata  = wd_in;
    mem_wmask  = w_mask_in;

    accept    = ce_in & ready_out;
    in_range  = ({1'b0, addr_in} < DEPTH_EXT);
    rd_accept = accept & ~we_in;
    rd_word   = in_range ? mem[addr_in] : '0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        mem_wdata = INIT_VALUE;
        mem_wmask = '1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        mem_we = accept & we_in & in_range;
      end
    endcase

    busy_err_d = busy_err_q | (ce_in & ~ready_out);
    oob_err_d  = oob_err_q | (accept & ~in_range);
    s1_valid_d = rd_accept;
    s1_data_d  = rd_accept ? rd_word : s1_data_q;
  end

  // Masked write into the array; the init engine drives this port with a full mask.
  // NOTE: the array itself has no reset -- the init engine clears it, and a reset term would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Control state, sticky flags and first read stage.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
      busy_err_q <= 1'b0;
      oob_err_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_err_q <= busy_err_d;
      oob_err_q  <= oob_err_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic            s2_valid_q, s2_valid_d;
    logic [BITS-1:0] s2_data_q, s2_data_d;

    // Second stage captures only completed reads so rd_out holds between them.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    // Extra output register stage for the 2-cycle read pipeline.
    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_out       = s2_data_q;
    assign rd_valid_out = s2_valid_q;
  end else begin : g_lat1
    assign rd_out       = s1_data_q;
    assign rd_valid_out = s1_valid_q;
  end

endmodule

// File: tb/tb_fakeram130_1rw_param.sv
// Directed bench: DUT a uses defaults (1024x32, latency 1, init 0);
// DUT b is 1000x32, latency 2, init 0x0000BEEF. Both share clk and reset.
module tb_fakeram130_1rw_param;

  logic        clk = 1'b0;
  logic        rst;

  logic        ce_a, we_a, ce_b, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] wd_a, mask_a, wd_b, mask_b;
  logic [31:0] rd_a, rd_b;
  logic        rv_a, rdy_a, be_a, oe_a;
  logic        rv_b, rdy_b, be_b, oe_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_a, cyc_b;
  bit seen_a, seen_b;

  logic [31:0] exp_rd [1:5];
  logic        exp_v  [1:5];

  always #5 clk = ~clk;

  fakeram130_1rw_param dut_a (
    .clk(clk), .rst_in(rst), .ce_in(ce_a), .we_in(we_a), .addr_in(addr_a),
    .wd_in(wd_a), .w_mask_in(mask_a), .rd_out(rd_a), .rd_valid_out(rv_a),
    .ready_out(rdy_a), .busy_err_out(be_a), .oob_err_out(oe_a)
  );

  fakeram130_1rw_param #(
    .BITS(32), .WORD_DEPTH(1000), .ADDR_WIDTH(10), .READ_LATENCY(2),
    .INIT_VALUE(32'h0000_BEEF), .INIT_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst_in(rst), .ce_in(ce_b), .we_in(we_b), .addr_in(addr_b),
    .wd_in(wd_b), .w_mask_in(mask_b), .rd_out(rd_b), .rd_valid_out(rv_b),
    .ready_out(rdy_b), .busy_err_out(be_b), .oob_err_out(oe_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on DUT a; returns at the negedge after the accepting edge.
  task automatic drive_a(input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] mask);
    ce_a = 1'b1; we_a = we; addr_a = addr; wd_a = wd; mask_a = mask;
    @(negedge clk);
    ce_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] mask);
    ce_b = 1'b1; we_b = we; addr_b = addr; wd_b = wd; mask_b = mask;
    @(negedge clk);
    ce_b = 1'b0; we_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ce_a = 0; we_a = 0; addr_a = 0; wd_a = 0; mask_a = 0;
    ce_b = 0; we_b = 0; addr_b = 0; wd_b = 0; mask_b = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_rv_a", rv_a, 1'b0);
    check("rst_rdy_a", rdy_a, 1'b0);
    check("rst_be_a", be_a, 1'b0);
    check("rst_oe_a", oe_a, 1'b0);
    check("rst_rdy_b", rdy_b, 1'b0);

    // Init timing: ready rises exactly WORD_DEPTH cycles after deassert
    rst = 1'b0;
    cyc_a = 0; cyc_b = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (rdy_a && cyc_a == 0) cyc_a = k;
      if (rdy_b && cyc_b == 0) cyc_b = k;
      if (cyc_a != 0 && cyc_b != 0) break;
    end
    check("init_cycles_a", cyc_a, 1024);
    check("init_cycles_b", cyc_b, 1000);
    check("no_busy_a", be_a, 1'b0);

    // Read of the last word after init, latency 1
    drive_a(1'b0, 10'h3FF, 32'h0, 32'h0);
    check("rd_3ff_data", rd_a, 32'h0000_0000);
    check("rd_3ff_valid", rv_a, 1'b1);
    @(negedge clk);
    check("rd_3ff_pulse_end", rv_a, 1'b0);

    // Masked write then read-after-write
    drive_a(1'b1, 10'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("wr1_rv", rv_a, 1'b0);
    check("wr1_rd_hold", rd_a, 32'h0);
    drive_a(1'b1, 10'd5, 32'h1234_5678, 32'h0000_FFFF);
    check("wr2_rv", rv_a, 1'b0);
    drive_a(1'b0, 10'd5, 32'h0, 32'h0);
    check("masked_rd", rd_a, 32'hFFFF_5678);
    check("masked_rv", rv_a, 1'b1);
    // Zero mask changes nothing and leaves rd_out alone
    drive_a(1'b1, 10'd5, 32'h0, 32'h0);
    check("zmask_rd_hold", rd_a, 32'hFFFF_5678);
    check("zmask_rv", rv_a, 1'b0);
    drive_a(1'b0, 10'd5, 32'h0, 32'h0);
    check("zmask_rd", rd_a, 32'hFFFF_5678);
    check("oe_a_clear", oe_a, 1'b0);

    // Pipelined reads on latency-2 DUT
    drive_b(1'b1, 10'd1, 32'hA1, 32'hFFFF_FFFF);
    drive_b(1'b1, 10'd2, 32'hA2, 32'hFFFF_FFFF);
    drive_b(1'b1, 10'd3, 32'hA3, 32'hFFFF_FFFF);
    exp_rd[1] = 32'h0;  exp_v[1] = 1'b0;
    exp_rd[2] = 32'hA1; exp_v[2] = 1'b1;
    exp_rd[3] = 32'hA2; exp_v[3] = 1'b1;
    exp_rd[4] = 32'hA3; exp_v[4] = 1'b1;
    exp_rd[5] = 32'hA3; exp_v[5] = 1'b0;
    ce_b = 1'b1; we_b = 1'b0; addr_b = 10'd1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("pipe_rv_%0d", i), rv_b, exp_v[i]);
      check($sformatf("pipe_rd_%0d", i), rd_b, exp_rd[i]);
      ce_b = (i < 3);
      addr_b = 10'(i + 1);
    end

    // Out of range on the non-power-of-two DUT
    check("oob_b_pre", oe_b, 1'b0);
    drive_b(1'b1, 10'd1000, 32'h0000_DEAD, 32'hFFFF_FFFF);
    check("oob_b_wr", oe_b, 1'b1);
    drive_b(1'b0, 10'd1000, 32'h0, 32'h0);
    @(negedge clk);
    check("oob_rd_data", rd_b, 32'h0);
    check("oob_rd_valid", rv_b, 1'b1);
    drive_b(1'b0, 10'd999, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_999_data", rd_b, 32'h0000_BEEF);
    check("rd_999_valid", rv_b, 1'b1);
    check("oe_a_still_clear", oe_a, 1'b0);

    // Busy error during init
    rst = 1'b1;
    @(negedge clk);
    check("rst2_rd_a", rd_a, 32'h0);
    check("rst2_oe_b", oe_b, 1'b0);
    rst = 1'b0;
    cyc_a = 0; seen_a = 0;
    for (int k = 1; k <= 2000; k++) begin
      ce_a = (k == 10); we_a = 1'b0; addr_a = 10'd0;
      @(negedge clk);
      if (rv_a) seen_a = 1;
      if (rdy_a) begin cyc_a = k; break; end
    end
    ce_a = 1'b0;
    check("busy_init_cycles", cyc_a, 1024);
    check("busy_no_valid", seen_a, 1'b0);
    check("busy_flag_a", be_a, 1'b1);
    check("busy_flag_b", be_b, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_sticky", be_a, 1'b1);

    // Reset with a read in flight on the latency-2 DUT
    drive_b(1'b0, 10'd5, 32'h0, 32'h0);
    @(negedge clk);
    check("pre_rst_rd_b", rd_b, 32'h0000_BEEF);
    ce_b = 1'b1; we_b = 1'b0; addr_b = 10'd6;
    @(negedge clk);
    ce_b = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_rd_b", rd_b, 32'h0);
    check("rst_async_rv_b", rv_b, 1'b0);
    check("rst_clears_busy", be_a, 1'b0);
    seen_a = 0; seen_b = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv_a) seen_a = 1;
      if (rv_b) seen_b = 1;
    end
    rst = 1'b0;
    // Reset again mid-init; init must restart and take the full length
    for (int k = 1; k < 500; k++) begin
      @(negedge clk);
      if (rv_a) seen_a = 1;
      if (rv_b) seen_b = 1;
    end
    rst = 1'b1;
    #1;
    check("mid_init_rdy_a", rdy_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc_a = 0; cyc_b = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (rv_a) seen_a = 1;
      if (rv_b) seen_b = 1;
      if (rdy_a && cyc_a == 0) cyc_a = k;
      if (rdy_b && cyc_b == 0) cyc_b = k;
      if (cyc_a != 0 && cyc_b != 0) break;
    end
    check("restart_cycles_a", cyc_a, 1024);
    check("restart_cycles_b", cyc_b, 1000);
    check("inflight_no_valid_a", seen_a, 1'b0);
    check("inflight_no_valid_b", seen_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
